// File: rtl/hqm_mem_reset_seq_scan_if.sv
// rtl/hqm_mem_reset_seq_scan_if.sv - channel reset request/status bundle for the reset sequencer
interface hqm_mem_reset_seq_scan_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] ch_rst_req;
    logic [NUM_CH-1:0] ch_rst_n_out;
    logic              seq_busy;
    logic              all_rel;

    modport master (
        output ch_rst_req,
        input  ch_rst_n_out,
        input  seq_busy,
        input  all_rel
    );

    modport slave (
        input  ch_rst_req,
        output ch_rst_n_out,
        output seq_busy,
        output all_rel
    );
endinterface

// File: rtl/hqm_mem_reset_seq_scan.sv
// rtl/hqm_mem_reset_seq_scan.sv - staged per-channel reset release with re-reset stretch and scan bypass
// Optional stretch/retrigger logic: HQM_MEM_RESET_SEQ_STRETCH_EN
module hqm_mem_reset_seq_scan #(
    parameter int NUM_CH     = 4,
    parameter int MIN_ASSERT = 8,
    parameter int STAGE_GAP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fscan_rstbypen,
    input  logic                       fscan_byprst_b,
    hqm_mem_reset_seq_scan_if.slave    bus
);
    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_STAGE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] MIN_M1   = 8'(MIN_ASSERT - 1);
    localparam logic [7:0] GAP_M1   = 8'(STAGE_GAP - 1);
    localparam logic [4:0] LAST_IDX = 5'(NUM_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4:0]        idx_q, idx_d;
    logic [NUM_CH-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0] active_d;
    logic [NUM_CH-1:0] ch_int_q, ch_int_d;
    logic              busy_q, all_rel_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == MIN_M1) begin
                    hold_d[0] = 1'b0;
                    cnt_d     = 8'd0;
                    idx_d     = 5'd1;
                    if (NUM_CH == 1) begin
                        state_d = ST_DONE;
                    end else if (STAGE_GAP == 0) begin
                        // zero gap: every channel leaves reset together with channel 0
                        hold_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STAGE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STAGE: begin
                if (cnt_q == GAP_M1) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (5'(k) == idx_q) hold_d[k] = 1'b0;
                    end
                    idx_d = idx_q + 5'd1;
                    cnt_d = 8'd0;
                    if (idx_q == LAST_IDX) state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

`ifdef HQM_MEM_RESET_SEQ_STRETCH_EN
    logic [7:0] str_q [NUM_CH];
    logic [7:0] str_d [NUM_CH];

    // a request reloads the full hold time, so repeated requests extend the low window
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.ch_rst_req[k])    str_d[k] = 8'(MIN_ASSERT);
            else if (str_q[k] != 0)   str_d[k] = str_q[k] - 8'd1;
            else                      str_d[k] = 8'd0;
            active_d[k] = (str_d[k] != 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst) str_q[k] <= 8'd0;
            else     str_q[k] <= str_d[k];
        end
    end
`else
    logic [NUM_CH-1:0] unused_ch_rst_req;
    assign unused_ch_rst_req = bus.ch_rst_req;
    assign active_d          = '0;
`endif

    assign ch_int_d = ~(hold_d | active_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= 8'd0;
            idx_q     <= 5'd0;
            hold_q    <= '1;
            ch_int_q  <= '0;
            busy_q    <= 1'b1;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            ch_int_q  <= ch_int_d;
            busy_q    <= (state_d != ST_DONE);
            all_rel_q <= &ch_int_d;
        end
    end

    // scan bypass overrides only the channel resets; status keeps reporting the sequencer
    assign bus.ch_rst_n_out = fscan_rstbypen ? {NUM_CH{fscan_byprst_b}} : ch_int_q;
    assign bus.seq_busy     = busy_q;
    assign bus.all_rel      = all_rel_q;
endmodule

// File: tb/tb_hqm_mem_reset_seq_scan.sv
// tb/tb_hqm_mem_reset_seq_scan.sv - randomized and directed checks of the reset sequencer against a timing model
module tb_hqm_mem_reset_seq_scan;
    localparam int NUM_CH = 4;
    localparam int MIN    = 8;
    localparam int GAP_A  = 4;
    localparam int GAP_B  = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic              byp_en;
    logic              byp_v;
    logic [NUM_CH-1:0] req;

    always #5 clk = ~clk;

    hqm_mem_reset_seq_scan_if #(.NUM_CH(NUM_CH)) if_a ();
    hqm_mem_reset_seq_scan_if #(.NUM_CH(NUM_CH)) if_b ();

    assign if_a.ch_rst_req = req;
    assign if_b.ch_rst_req = req;

    hqm_mem_reset_seq_scan #(.NUM_CH(NUM_CH), .MIN_ASSERT(MIN), .STAGE_GAP(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .fscan_rstbypen(byp_en), .fscan_byprst_b(byp_v), .bus(if_a)
    );

    hqm_mem_reset_seq_scan #(.NUM_CH(NUM_CH), .MIN_ASSERT(MIN), .STAGE_GAP(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .fscan_rstbypen(byp_en), .fscan_byprst_b(byp_v), .bus(if_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // model: t counts edges since reset; channel k is out of reset once t >= MIN + k*gap
    // and no request was seen within the last MIN edges
    int t          = 0;
    bit model_ok   = 0;
    int last_req [NUM_CH];
    bit req_seen [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_int(input int gap);
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) begin
            bit rel = (t >= MIN + k * gap);
            bit str = 1'b0;
`ifdef HQM_MEM_RESET_SEQ_STRETCH_EN
            str = req_seen[k] && (t < last_req[k] + MIN);
`endif
            v[k] = rel && !str;
        end
        return v;
    endfunction

    function automatic logic exp_busy(input int gap);
        return (t < MIN + (NUM_CH - 1) * gap);
    endfunction

    task automatic check_ch(input string sfx);
        logic [NUM_CH-1:0] ea, eb;
        ea = byp_en ? {NUM_CH{byp_v}} : exp_int(GAP_A);
        eb = byp_en ? {NUM_CH{byp_v}} : exp_int(GAP_B);
        check({"ch_a_", sfx}, 32'(if_a.ch_rst_n_out), 32'(ea));
        check({"ch_b_", sfx}, 32'(if_b.ch_rst_n_out), 32'(eb));
    endtask

    task automatic check_all();
        check_ch("seq");
        check("busy_a", 32'(if_a.seq_busy), 32'(exp_busy(GAP_A)));
        check("busy_b", 32'(if_b.seq_busy), 32'(exp_busy(GAP_B)));
        check("allrel_a", 32'(if_a.all_rel), 32'(&exp_int(GAP_A)));
        check("allrel_b", 32'(if_b.all_rel), 32'(&exp_int(GAP_B)));
    endtask

    task automatic tick(input logic r, input logic [NUM_CH-1:0] q, input logic be, input logic bv);
        rst = r; req = q; byp_en = be; byp_v = bv;
        #1;
        if (model_ok) check_ch("comb");
        @(posedge clk);
        if (rst) begin
            t = 0;
            model_ok = 1;
            for (int k = 0; k < NUM_CH; k++) req_seen[k] = 0;
        end else begin
            t++;
            for (int k = 0; k < NUM_CH; k++) begin
                if (req[k]) begin
                    last_req[k] = t;
                    req_seen[k] = 1;
                end
            end
        end
        @(negedge clk);
        if (model_ok) check_all();
    endtask

    int rise_a [NUM_CH];
    int rise_b [NUM_CH];
    int busy_fall_a;
    int allrel_rise_a;
    int low_cnt;
    int e_req;

    initial begin
        rst = 1; req = '0; byp_en = 0; byp_v = 0;
        @(negedge clk);

        // reset state
        repeat (3) tick(1, '0, 0, 0);
        check("rst_ch", 32'(if_a.ch_rst_n_out), 32'h0);
        check("rst_busy", 32'(if_a.seq_busy), 32'h1);
        check("rst_allrel", 32'(if_a.all_rel), 32'h0);

        // release order, recorded independently of the model
        for (int k = 0; k < NUM_CH; k++) begin rise_a[k] = -1; rise_b[k] = -1; end
        busy_fall_a = -1; allrel_rise_a = -1;
        repeat (30) begin
            tick(0, '0, 0, 0);
            for (int k = 0; k < NUM_CH; k++) begin
                if (rise_a[k] < 0 && if_a.ch_rst_n_out[k]) rise_a[k] = t - 1;
                if (rise_b[k] < 0 && if_b.ch_rst_n_out[k]) rise_b[k] = t - 1;
            end
            if (busy_fall_a < 0 && !if_a.seq_busy) busy_fall_a = t - 1;
            if (allrel_rise_a < 0 && if_a.all_rel) allrel_rise_a = t - 1;
        end
        // values are edge offsets from E0
        for (int k = 0; k < NUM_CH; k++) begin
            check("rise_order_a", 32'(rise_a[k]), 32'(7 + 4 * k));
            check("rise_zero_gap_b", 32'(rise_b[k]), 32'd7);
        end
        check("busy_fall_a", 32'(busy_fall_a), 32'd19);
        check("allrel_rise_a", 32'(allrel_rise_a), 32'd19);

        // stretch retrigger in DONE on channel 2
        low_cnt = 0;
        tick(0, 4'b0100, 0, 0);
        e_req = t;
        if (!if_a.ch_rst_n_out[2]) low_cnt++;
        repeat (2) begin tick(0, '0, 0, 0); if (!if_a.ch_rst_n_out[2]) low_cnt++; end
        tick(0, 4'b0100, 0, 0);
        if (!if_a.ch_rst_n_out[2]) low_cnt++;
        repeat (12) begin tick(0, '0, 0, 0); if (!if_a.ch_rst_n_out[2]) low_cnt++; end
`ifdef HQM_MEM_RESET_SEQ_STRETCH_EN
        check("stretch_low_cycles", 32'(low_cnt), 32'd11);
`else
        check("req_ignored", 32'(low_cnt), 32'd0);
`endif
        check("stretch_end_t", 32'(t - e_req), 32'd15);

        // reset mid-sequence at E0+13
        tick(1, '0, 0, 0);
        while (t < 13) tick(0, '0, 0, 0);
        tick(1, '0, 0, 0);
        check("midrst_ch", 32'(if_a.ch_rst_n_out), 32'h0);
        check("midrst_allrel", 32'(if_a.all_rel), 32'h0);
        repeat (25) tick(0, '0, 0, 0);

        // scan bypass while sequencing
        tick(1, '0, 0, 0);
        repeat (5) tick(0, '0, 0, 0);
        tick(0, '0, 1, 0);
        tick(0, '0, 1, 1);
        check("byp_high", 32'(if_a.ch_rst_n_out), 32'hf);
        check("byp_busy", 32'(if_a.seq_busy), 32'h1);
        tick(0, '0, 1, 0);
        check("byp_low", 32'(if_b.ch_rst_n_out), 32'h0);
        repeat (4) tick(0, '0, 1, 1);
        repeat (20) tick(0, '0, 0, 0);

        // randomized stimulus
        repeat (3000) begin
            logic              r;
            logic [NUM_CH-1:0] q;
            r = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < NUM_CH; k++) q[k] = ($urandom_range(0, 19) == 0);
            tick(r, q, ($urandom_range(0, 9) == 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
